// File: rtl/accessory_hub_pkg.sv
// accessory_hub_pkg: shared input-path state encoding and select-width helper
package accessory_hub_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, SHIFT} in_state_t;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hub_fifo.sv
// hub_fifo: per-channel output word FIFO with sticky overflow and registered head
module hub_fifo #(
  parameter int WORD_BITS = 29,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLOCK,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [WORD_BITS-1:0] push_data,
  input  logic                 pop,
  output logic                 out_valid,
  output logic [WORD_BITS-1:0] out_data,
  output logic                 full,
  output logic                 ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [WORD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign out_valid = count != '0;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign do_pop = pop && out_valid;
  assign do_push = push && (!full || do_pop);
  assign out_data = out_valid ? mem[rd] : '0;
  always_ff @(posedge CLOCK)
    if (do_push) mem[wr] <= push_data;
  always_ff @(posedge CLOCK or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (push && !do_push) ovf <= 1'b1;
    end
endmodule

// File: rtl/accessory_hub.sv
// accessory_hub: multi-channel bridge between G-15 serial PL19/PL20 signals and word-parallel accessories
module accessory_hub
  import accessory_hub_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int WORD_BITS = 29,
  parameter int FIFO_DEPTH = 4,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic                      CLOCK,
  input  logic                      rst_n,
  input  logic [SEL_W-1:0]          ch_sel,
  input  logic [SEL_W-1:0]          out_sel,
  input  logic                      PL19_START_INPUT,
  input  logic                      PL19_STOP_INPUT,
  input  logic                      PL19_SHIFT_CMD,
  input  logic                      PL20_OUTPUT,
  input  logic                      PL20_OUTPUT_SHIFT,
  input  logic                      PL19_WRITE_PULSE,
  output logic                      PL19_INPUT,
  output logic                      PL19_READY_IN,
  output logic                      PL20_READY_OUT,
  input  logic [N_CH-1:0]           in_valid,
  input  logic [N_CH*WORD_BITS-1:0] in_data,
  output logic [N_CH-1:0]           in_ready,
  output logic [N_CH-1:0]           out_valid,
  output logic [N_CH*WORD_BITS-1:0] out_data,
  input  logic [N_CH-1:0]           out_ready,
  output logic [N_CH-1:0]           ovf,
  output logic                      sel_err
);
  localparam int CW = $clog2(WORD_BITS + 1);
  in_state_t state, state_n;
  logic [SEL_W-1:0] ch;
  logic [WORD_BITS-1:0] insr, outsr, out_word;
  logic [CW-1:0] cnt;
  logic load, shift, ch_ok, out_ok, start_ok, start_bad;
  logic [N_CH-1:0] full, push;
  assign ch_ok = 32'(ch_sel) < N_CH;
  assign out_ok = 32'(out_sel) < N_CH;
  assign start_ok = state == IDLE && PL19_START_INPUT && ch_ok;
  assign start_bad = state == IDLE && PL19_START_INPUT && !ch_ok;
  always_comb begin
    state_n = state;
    load = 1'b0;
    shift = 1'b0;
    case (state)
      IDLE: state_n = start_ok ? WAIT : IDLE;
      WAIT: begin
        load = in_valid[ch] && !PL19_STOP_INPUT;
        state_n = PL19_STOP_INPUT ? IDLE : load ? SHIFT : WAIT;
      end
      SHIFT: begin
        shift = PL19_SHIFT_CMD && !PL19_STOP_INPUT;
        state_n = PL19_STOP_INPUT ? IDLE : (shift && cnt == CW'(WORD_BITS - 1)) ? WAIT : SHIFT;
      end
      default: state_n = IDLE;
    endcase
  end
  assign in_ready = load ? N_CH'(1) << ch : '0;
  assign PL19_READY_IN = state == SHIFT;
  assign PL19_INPUT = state == SHIFT && insr[0];
  // the new bit is merged before a same-cycle write so the pushed word includes it
  assign out_word = PL20_OUTPUT_SHIFT ? {PL20_OUTPUT, outsr[WORD_BITS-1:1]} : outsr;
  assign PL20_READY_OUT = rst_n && out_ok && !full[out_sel];
  always_ff @(posedge CLOCK or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ch <= '0;
      insr <= '0;
      cnt <= '0;
      outsr <= '0;
      sel_err <= 1'b0;
    end else begin
      state <= state_n;
      if (start_ok) ch <= ch_sel;
      if (load) begin
        insr <= in_data[ch*WORD_BITS +: WORD_BITS];
        cnt <= '0;
      end else if (shift) begin
        insr <= insr >> 1;
        cnt <= cnt + 1'b1;
      end
      outsr <= PL19_WRITE_PULSE ? '0 : out_word;
      if (start_bad || (PL19_WRITE_PULSE && !out_ok)) sel_err <= 1'b1;
    end
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign push[k] = PL19_WRITE_PULSE && 32'(out_sel) == k;
    hub_fifo #(.WORD_BITS(WORD_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .CLOCK(CLOCK),
      .rst_n(rst_n),
      .push(push[k]),
      .push_data(out_word),
      .pop(out_ready[k]),
      .out_valid(out_valid[k]),
      .out_data(out_data[k*WORD_BITS +: WORD_BITS]),
      .full(full[k]),
      .ovf(ovf[k])
    );
  end
endmodule

// File: tb/tb_accessory_hub.sv
// tb_accessory_hub: randomized scoreboard bench against a queue-based reference model
module tb_accessory_hub;
  localparam int N_CH = 3;
  localparam int WB = 29;
  localparam int DEPTH = 4;
  localparam int SW = 2;
  logic clk, rst_n;
  logic [SW-1:0] ch_sel, out_sel;
  logic start, stop, shift_cmd, pl20, oshift, write;
  logic pl19_input, ready_in, ready_out, sel_err;
  logic [N_CH-1:0] in_valid, in_ready, out_valid, out_ready, ovf;
  logic [N_CH*WB-1:0] in_data, out_data;
  int n_chk = 0, n_pass = 0;
  bit active;
  int ach;
  logic ibits[$];
  logic obits[$];
  logic [WB-1:0] fq [N_CH][$];
  logic [N_CH-1:0] ovf_e;
  logic sel_e;

  accessory_hub #(.N_CH(N_CH), .WORD_BITS(WB), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK(clk), .rst_n(rst_n), .ch_sel(ch_sel), .out_sel(out_sel),
    .PL19_START_INPUT(start), .PL19_STOP_INPUT(stop), .PL19_SHIFT_CMD(shift_cmd),
    .PL20_OUTPUT(pl20), .PL20_OUTPUT_SHIFT(oshift), .PL19_WRITE_PULSE(write),
    .PL19_INPUT(pl19_input), .PL19_READY_IN(ready_in), .PL20_READY_OUT(ready_out),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ovf(ovf), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference model: words as bit queues, FIFOs as bounded word queues
  initial begin
    logic [WB-1:0] word;
    int pk;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        active = 0;
        ibits.delete();
        obits.delete();
        for (int k = 0; k < N_CH; k++) fq[k].delete();
        ovf_e = '0;
        sel_e = 1'b0;
      end else begin
        if (!active) begin
          if (start) begin
            if (int'(ch_sel) < N_CH) begin active = 1; ach = int'(ch_sel); end
            else sel_e = 1'b1;
          end
        end else if (stop) begin
          active = 0;
          ibits.delete();
        end else if (ibits.size() == 0) begin
          if (in_valid[ach]) for (int i = 0; i < WB; i++) ibits.push_back(in_data[ach*WB+i]);
        end else if (shift_cmd) void'(ibits.pop_front());
        if (oshift) obits.push_back(pl20);
        pk = -1;
        word = '0;
        if (write) begin
          for (int i = 0; i < obits.size(); i++) word[WB-obits.size()+i] = obits[i];
          obits.delete();
          if (int'(out_sel) < N_CH) pk = int'(out_sel);
          else sel_e = 1'b1;
        end
        for (int k = 0; k < N_CH; k++) begin
          if (out_ready[k] && fq[k].size() > 0) void'(fq[k].pop_front());
          if (pk == k) begin
            if (fq[k].size() < DEPTH) fq[k].push_back(word);
            else ovf_e[k] = 1'b1;
          end
        end
      end
    end
  end

  // monitor
  initial begin
    logic [N_CH-1:0] exp_ir;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_ir = '0;
        if (active && ibits.size() == 0 && !stop && in_valid[ach]) exp_ir[ach] = 1'b1;
        chk("in_ready", in_ready, exp_ir);
        chk("pl19_input", pl19_input, ibits.size() > 0 ? ibits[0] : 1'b0);
        chk("ready_in", ready_in, ibits.size() > 0);
        for (int k = 0; k < N_CH; k++) begin
          chk("out_valid", out_valid[k], fq[k].size() > 0);
          if (fq[k].size() > 0) chk("out_data", out_data[k*WB +: WB], fq[k][0]);
        end
        chk("ovf", ovf, ovf_e);
        chk("sel_err", sel_err, sel_e);
        if (int'(out_sel) < N_CH) chk("ready_out", ready_out, fq[out_sel].size() < DEPTH);
        else chk("ready_out_bad_sel", ready_out, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    start = 0; stop = 0; shift_cmd = 0; oshift = 0; write = 0; pl20 = 0;
    in_valid = '0; out_ready = '0;
  endtask

  task automatic send_out(input int sel, input logic [WB-1:0] w, input int n);
    out_sel = SW'(sel);
    for (int i = 0; i < n; i++) begin
      pl20 = w[i]; oshift = 1; tick();
    end
    oshift = 0; write = 1; tick(); write = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready_in"}, ready_in, 0);
    chk({tag, "_pl19_input"}, pl19_input, 0);
    chk({tag, "_ready_out"}, ready_out, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data[63:0], 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_sel_err"}, sel_err, 0);
  endtask

  initial begin
    int ocnt;
    rst_n = 0; ch_sel = '0; out_sel = '0; in_data = '0;
    clr();
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1; tick();
    // single input word on channel 1
    ch_sel = 1; start = 1; tick(); start = 0;
    in_data[WB +: WB] = 29'h1ABCDEF1; in_valid = 3'b010; tick(); in_valid = '0;
    repeat (WB) begin shift_cmd = 1; tick(); end
    shift_cmd = 0; repeat (2) tick();
    // stop together with a shift mid-word
    in_data[WB +: WB] = 29'h0F0F0F0F; in_valid = 3'b010; tick(); in_valid = '0;
    repeat (10) begin shift_cmd = 1; tick(); end
    stop = 1; tick(); stop = 0; shift_cmd = 0;
    in_valid = 3'b010; repeat (3) tick(); in_valid = '0;
    // output round trip
    send_out(0, 29'h5, WB); tick();
    out_ready[0] = 1; tick(); out_ready = '0;
    // overflow, then full push+pop
    for (int j = 0; j < 5; j++) send_out(1, WB'(j + 1), 3);
    tick();
    out_sel = 1; pl20 = 1; oshift = 1; tick(); oshift = 0;
    write = 1; out_ready[1] = 1; tick(); write = 0;
    repeat (6) tick(); out_ready = '0;
    // invalid channel
    ch_sel = 3; start = 1; tick(); start = 0; tick();
    // async reset mid-shift with state present everywhere
    send_out(2, WB'($urandom), WB);
    ch_sel = 0; start = 1; tick(); start = 0;
    in_data[0 +: WB] = WB'($urandom); in_valid = 3'b001; tick(); in_valid = '0;
    repeat (5) begin shift_cmd = 1; tick(); end
    shift_cmd = 0;
    rst_n = 0; #1;
    chk_zero("async_reset");
    tick(); rst_n = 1; tick();
    // randomized traffic
    ocnt = 0;
    repeat (2000) begin
      for (int k = 0; k < N_CH; k++) begin
        in_data[k*WB +: WB] = WB'($urandom);
        in_valid[k] = ($urandom_range(0, 2) == 0);
        out_ready[k] = ($urandom_range(0, 2) == 0);
      end
      ch_sel = SW'($urandom_range(0, 3));
      out_sel = SW'($urandom_range(0, 3));
      start = ($urandom_range(0, 19) == 0);
      stop = ($urandom_range(0, 39) == 0);
      shift_cmd = $urandom_range(0, 1) == 1;
      pl20 = $urandom_range(0, 1) == 1;
      oshift = ocnt < WB && $urandom_range(0, 1) == 1;
      write = ($urandom_range(0, 7) == 0);
      ocnt = write ? 0 : ocnt + int'(oshift);
      tick();
    end
    clr();
    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
